// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  // Default operand, quotient and remainder width.
  localparam int unsigned DIV_WIDTH = 16;

  // Controller states, kept as plain constants so older tools can consume them.
  typedef logic [1:0] div_state_t;
  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t RUN  = 2'd1;
  localparam div_state_t DONE = 2'd2;

  // Quotient reported for a divide by zero.
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational (WIDTH+1)-bit trial subtractor: minuend + ~{0,subtrahend} + 1.
// The MSB of the raw difference is the borrow; only the low WIDTH bits are
// forwarded because a kept difference never has that bit set.
module div_sub_stage
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] b_inv;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] carry;

  // Add with inverted operand, carry-in of one; generate/propagate per bit.
  always_comb begin
    b_inv    = ~{1'b0, subtrahend};
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]       = minuend[i] ^ b_inv[i] ^ carry[i];
      carry[i + 1] = (minuend[i] & b_inv[i]) | ((minuend[i] ^ b_inv[i]) & carry[i]);
    end
    // Top bit needs no carry-out: its sum bit is the borrow.
    sum[WIDTH] = minuend[WIDTH] ^ b_inv[WIDTH] ^ carry[WIDTH];
  end

  assign diff   = sum[WIDTH-1:0];
  assign borrow = sum[WIDTH];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Divide by zero completes immediately with a flag.
module seq_divider16
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned          CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Partial remainder. The (WIDTH+1)-bit remainder's MSB is always zero
  // between iterations (R < D), so only the low WIDTH bits are stored.
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_in;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] part_step;
  logic [WIDTH-1:0] shift_step;

  assign trial_in = {part_q, shift_q[WIDTH-1]};

  div_sub_stage #(
    .WIDTH(WIDTH)
  ) u_sub (
    .minuend   (trial_in),
    .subtrahend(dsr_q),
    .diff      (trial_diff),
    .borrow    (trial_borrow)
  );

  // On borrow restore the shifted remainder; a restore never sets bit WIDTH.
  assign part_step  = trial_borrow ? trial_in[WIDTH-1:0] : trial_diff;
  assign shift_step = {shift_q[WIDTH-2:0], ~trial_borrow};

  // Next-state logic for controller, datapath and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    shift_d = shift_q;
    dsr_d   = dsr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor != '0) begin
            part_d  = '0;
            shift_d = dividend;
            dsr_d   = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            // All-ones quotient at any WIDTH.
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      RUN: begin
        part_d  = part_step;
        shift_d = shift_step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          quot_d  = shift_step;
          rem_d   = part_step;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      shift_q <= '0;
      dsr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      shift_q <= shift_d;
      dsr_q   <= dsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: vector table, corner sequences and a
// random sweep, all checked through an expected-result queue.
module tb_seq_divider16;
  import div_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request from a negedge, then follow it to its done pulse.
  // inject_at > 0 pulses a second start that many cycles after the accept.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int inject_at);
    vec_t e;
    int   n;
    int   busy_cnt;
    bit   seen;
    e        = '{a, b, eq, er, ez};
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    seen     = 1'b0;
    busy_cnt = 0;
    n        = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (inject_at > 0 && n == inject_at) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
      end
      if (inject_at > 0 && n == inject_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("sb_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        check("latency", 32'(n - 1), (e.dvs == '0) ? 32'd0 : 32'd16);
        check("busy_cycles", 32'(busy_cnt), (e.dvs == '0) ? 32'd1 : 32'd17);
      end
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    int   extra;
    logic [W-1:0] a;
    logic [W-1:0] b;

    vecs[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
    vecs[1]  = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000,  1'b0};
    vecs[3]  = '{16'd3,     16'd9,     16'd0,     16'd3,     1'b0};
    vecs[4]  = '{16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1};
    vecs[5]  = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
    vecs[6]  = '{16'd7,     16'd7,     16'd1,     16'd0,     1'b0};
    vecs[7]  = '{16'hFFFF,  16'd2,     16'd32767, 16'd1,     1'b0};
    vecs[8]  = '{16'd0,     16'd0,     16'hFFFF,  16'd0,     1'b1};
    vecs[9]  = '{16'd1234,  16'd1,     16'd1234,  16'd0,     1'b0};
    vecs[10] = '{16'h8000,  16'h8001,  16'h0000,  16'h8000,  1'b0};
    vecs[11] = '{16'hFFFE,  16'hFFFF,  16'h0000,  16'hFFFE,  1'b0};

    // Reset state.
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table, issued back to back.
    for (int i = 0; i < 12; i++) begin
      do_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz, 0);
    end

    // Second start during RUN is ignored: one done, first operands' result.
    do_div(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 5);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored_start_no_done", 32'(extra), 32'd0);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Reset mid-RUN discards the operation.
    dividend = 16'd40000;
    divisor  = 16'd123;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    rst   = 1'b0;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrst_quiet", 32'(extra), 32'd0);
    do_div(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 0);

    // Random sweep against a reference model.
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if (b == '0) do_div(a, b, DIV0_QUOTIENT, a, 1'b1, 0);
      else         do_div(a, b, a / b, a % b, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
